// File: rtl/weight_rom_stream_ctrl_if.sv
// weight_rom_stream_ctrl_if: ROM read port plus valid/ready output stream of the weight ROM sequencer
//   rom_addr/rom_ce/rom_q : ROM address0/ce0/q0
//   data_out/_last/_valid/_ready : buffered word stream with last-of-pass marker
interface weight_rom_stream_ctrl_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_ce;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_last;
  logic                  data_out_valid;
  logic                  data_out_ready;
  modport master (output rom_addr, rom_ce, data_out, data_out_last, data_out_valid, input rom_q, data_out_ready);
  modport slave (input rom_addr, rom_ce, data_out, data_out_last, data_out_valid, output rom_q, data_out_ready);
endinterface

// File: rtl/weight_rom_stream_ctrl.sv
// weight_rom_stream_ctrl: start/done sequencer replaying a 2-cycle-latency ROM num_passes times into a backpressured stream
//   clk, rst (async, active-high)
//   start, num_passes : run request, pass count latched in IDLE
//   busy, done        : high in RUN/DRAIN, one-cycle completion pulse
//   bus               : ROM read port and output stream (master side)
module weight_rom_stream_ctrl #(
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH       = 576,
  parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int PASS_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int ROM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  weight_rom_stream_ctrl_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CW:0] FD = (CW + 1)'(FIFO_DEPTH);
  logic [1:0]            state;
  logic [PASS_WIDTH-1:0] passes, pass_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ROM_LATENCY-1:0] vsr, lsr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] lmem;
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  logic [CW:0]           occ;
  logic                  pop, wr, issue, wrap, final_issue;
  assign pop  = bus.data_out_valid & bus.data_out_ready;
  assign wr   = vsr[ROM_LATENCY-1];
  // Reads in flight plus buffered words, with this cycle's pop already freeing its slot,
  // so every issued read is guaranteed a FIFO entry when it returns.
  assign occ  = (CW + 1)'($countones(vsr)) + {1'b0, count} - {{CW{1'b0}}, pop};
  assign issue = (state == RUN) && (occ < FD);
  assign wrap  = addr == LAST_ADDR;
  assign final_issue = issue && wrap && (pass_cnt == passes - 1'b1);
  assign busy = state != IDLE;
  assign bus.rom_ce = busy;
  assign bus.rom_addr = addr;
  assign bus.data_out = mem[rptr];
  assign bus.data_out_last = lmem[rptr];
  assign bus.data_out_valid = count != '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      passes   <= '0;
      pass_cnt <= '0;
      addr     <= '0;
      vsr      <= '0;
      lsr      <= '0;
      lmem     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      done     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      done  <= 1'b0;
      // Non-issue cycles shift in a 0 tag so the repeated ROM read is dropped.
      vsr   <= {vsr[ROM_LATENCY-2:0], issue};
      lsr   <= {lsr[ROM_LATENCY-2:0], issue & wrap};
      count <= count + CW'(wr) - CW'(pop);
      if (wr) begin
        mem[wptr]  <= bus.rom_q;
        lmem[wptr] <= lsr[ROM_LATENCY-1];
        wptr       <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (issue) begin
        addr <= wrap ? '0 : addr + 1'b1;
        if (wrap) pass_cnt <= pass_cnt + 1'b1;
      end
      if (state == IDLE && start) begin
        if (num_passes == '0) done <= 1'b1;
        else begin
          state    <= RUN;
          passes   <= num_passes;
          pass_cnt <= '0;
          addr     <= '0;
        end
      end
      if (final_issue) state <= DRAIN;
      if (state == DRAIN && vsr == '0 && count == CW'(1) && pop) begin
        state <= IDLE;
        done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_weight_rom_stream_ctrl.sv
// tb_weight_rom_stream_ctrl: randomized-backpressure bench with a transaction-level stream model
module tb_weight_rom_stream_ctrl;
  localparam int DW = 16, D = 8, AW = 4, PW = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [PW-1:0] num_passes = '0;
  logic busy, done;
  weight_rom_stream_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  weight_rom_stream_ctrl #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .PASS_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_passes(num_passes), .busy(busy), .done(done), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] word(int k);
    return DW'(32'hA500 + k);
  endfunction
  logic [AW-1:0] a1;
  always @(posedge clk) if (bus.rom_ce) begin
    a1 <= bus.rom_addr;
    bus.rom_q <= word(int'(a1));
  end
  int ready_mode = 0;
  initial forever begin
    @(posedge clk);
    #2;
    bus.data_out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ($urandom_range(0, 99) < 30) : 1'b0;
  end
  int vectors = 0, errors = 0, cyc = 0;
  bit m_busy = 0, m_done = 0, busy_p = 0, hold_p = 0;
  int total = 0, accepted = 0, issued = 0, lasts = 0, dones = 0;
  int first_valid = -1, last_beat = -1, done_cyc = -1;
  logic [AW-1:0] addr_p = '0;
  logic [DW-1:0] data_p = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    bit pop;
    cyc++;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_valid", bus.data_out_valid, 0);
      chk("rst_addr", bus.rom_addr, 0);
      m_busy = 0; m_done = 0; busy_p = 0; hold_p = 0;
      total = 0; accepted = 0; issued = 0;
    end else begin
      pop = bus.data_out_valid && bus.data_out_ready;
      chk("busy", busy, m_busy);
      chk("rom_ce", bus.rom_ce, m_busy);
      chk("done", done, m_done);
      if (done) begin dones++; done_cyc = cyc; end
      if (!m_busy) chk("idle_valid", bus.data_out_valid, 0);
      if (hold_p) begin
        chk("hold_valid", bus.data_out_valid, 1);
        chk("hold_data", bus.data_out, data_p);
      end
      if (busy_p && bus.rom_addr !== addr_p) begin
        chk("issue_addr", addr_p, issued % D);
        issued++;
        chk("outstanding_le4", issued - accepted <= 4, 1);
      end
      if (bus.data_out_valid && first_valid < 0) first_valid = cyc;
      if (pop) begin
        chk("beat_data", bus.data_out, word(accepted % D));
        chk("beat_last", bus.data_out_last, accepted % D == D - 1);
        lasts += int'(bus.data_out_last);
        accepted++;
        last_beat = cyc;
        chk("beat_le_total", accepted <= total, 1);
      end
      hold_p = pop ? 1'b0 : bus.data_out_valid;
      data_p = bus.data_out;
      busy_p = m_busy;
      addr_p = bus.rom_addr;
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          if (num_passes == 0) m_done = 1;
          else begin
            m_busy = 1; total = int'(num_passes) * D;
            accepted = 0; issued = 0; lasts = 0; first_valid = -1;
          end
        end
      end else if (pop && accepted == total) begin
        m_busy = 0; m_done = 1;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input int np, output int s);
    start = 1'b1;
    num_passes = PW'(np);
    tick();
    s = cyc;
    start = 1'b0;
  endtask
  task automatic wait_idle(input int n);
    bit ok = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    repeat (2) tick();
  endtask
  task automatic wait_beats(input int k, input int n);
    bit ok = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (accepted >= k) begin ok = 1; break; end
    end
    if (!ok) chk("beat_timeout", 0, 1);
  endtask
  initial begin
    int s;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    ready_mode = 0; dones = 0;
    do_start(1, s);
    wait_idle(100);
    chk("basic_first_valid", first_valid, s + 4);
    chk("basic_last_beat", last_beat, s + 11);
    chk("basic_done_cyc", done_cyc, s + 12);
    chk("basic_beats", accepted, 8);
    chk("basic_lasts", lasts, 1);
    chk("basic_dones", dones, 1);
    ready_mode = 1; dones = 0;
    do_start(2, s);
    wait_idle(600);
    chk("bp_beats", accepted, 16);
    chk("bp_lasts", lasts, 2);
    chk("bp_dones", dones, 1);
    ready_mode = 0; dones = 0;
    do_start(1, s);
    wait_beats(2, 50);
    ready_mode = 2;
    repeat (20) tick();
    chk("stall_outstanding", issued - accepted, 4);
    chk("stall_valid", bus.data_out_valid, 1);
    ready_mode = 0;
    wait_idle(100);
    chk("stall_beats", accepted, 8);
    chk("stall_dones", dones, 1);
    dones = 0;
    do_start(0, s);
    repeat (4) tick();
    chk("zero_done_cyc", done_cyc, s + 1);
    chk("zero_dones", dones, 1);
    chk("zero_busy", busy, 0);
    dones = 0;
    do_start(1, s);
    repeat (5) tick();
    start = 1'b1;
    num_passes = 5;
    tick();
    start = 1'b0;
    wait_idle(100);
    chk("sib_beats", accepted, 8);
    chk("sib_total", total, 8);
    chk("sib_dones", dones, 1);
    do_start(1, s);
    wait_beats(3, 50);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ce", bus.rom_ce, 0);
    chk("mid_rst_addr", bus.rom_addr, 0);
    chk("mid_rst_valid", bus.data_out_valid, 0);
    chk("mid_rst_last", bus.data_out_last, 0);
    chk("mid_rst_data", bus.data_out, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    dones = 0;
    do_start(1, s);
    wait_idle(100);
    chk("post_rst_first_valid", first_valid, s + 4);
    chk("post_rst_beats", accepted, 8);
    chk("post_rst_lasts", lasts, 1);
    chk("post_rst_dones", dones, 1);
    ready_mode = 1; dones = 0;
    do_start(3, s);
    wait_idle(900);
    chk("rand3_beats", accepted, 24);
    chk("rand3_lasts", lasts, 3);
    chk("rand3_dones", dones, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
